// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 slave giving read/write access to a small register file
module spi_regfile #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       COPI,
  input  logic                       cs,
  output logic                       CIPO,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int F  = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(F + 1);
  localparam int SW = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam logic [CW-1:0] HDR_LAST = CW'(ADDR_W);
  localparam logic [CW-1:0] HDR_BITS = CW'(ADDR_W + 1);
  localparam logic [CW-1:0] FRM_LAST = CW'(F - 1);
  localparam logic [ADDR_W:0] NREG = NUM_REGS[ADDR_W:0];

  typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;

  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sclk_s, r_copi_s, r_cs_s;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_sr, w_sr_next;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_osr, w_rd_val;
  logic [ADDR_W-1:0] r_addr, r_waddr;
  logic r_rw, r_pend, r_strobe, r_ferr, r_cipo;
  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_copi, w_active, w_shift_in;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sclk_s <= '0;
      r_copi_s <= '0;
      r_cs_s   <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], sclk};
      r_copi_s <= {r_copi_s[SYNC_STAGES-2:0], COPI};
      r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], cs};
    end

  assign w_sclk_rise = r_sclk_s[SYNC_STAGES-2] & ~r_sclk_s[SYNC_STAGES-1];
  assign w_sclk_fall = ~r_sclk_s[SYNC_STAGES-2] & r_sclk_s[SYNC_STAGES-1];
  assign w_cs_rise   = r_cs_s[SYNC_STAGES-2] & ~r_cs_s[SYNC_STAGES-1];
  assign w_cs_fall   = ~r_cs_s[SYNC_STAGES-2] & r_cs_s[SYNC_STAGES-1];
  assign w_copi      = r_copi_s[SYNC_STAGES-1];
  assign w_active    = (r_state == HEADER) || (r_state == DATA);
  assign w_shift_in  = w_active && w_sclk_rise && !w_cs_rise;
  assign w_sr_next   = {r_sr[SW-2:0], w_copi};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   w_next = w_cs_fall ? HEADER : IDLE;
      HEADER: w_next = w_cs_rise ? IDLE : (w_sclk_rise && r_cnt == HDR_LAST) ? DATA : HEADER;
      DATA:   w_next = w_cs_rise ? IDLE : (w_sclk_rise && r_cnt == FRM_LAST) ? DONE : DATA;
      DONE:   w_next = w_cs_rise ? IDLE : DONE;
    endcase
  end

  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (w_sr_next[ADDR_W-1:0] == ADDR_W'(k)) w_rd_val = r_regs[k];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt    <= '0;
      r_sr     <= '0;
      r_osr    <= '0;
      r_addr   <= '0;
      r_waddr  <= '0;
      r_rw     <= 1'b0;
      r_pend   <= 1'b0;
      r_strobe <= 1'b0;
      r_ferr   <= 1'b0;
      r_cipo   <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else begin
      r_ferr   <= w_active && w_cs_rise;
      r_strobe <= r_pend;
      r_pend   <= 1'b0;
      if (r_pend) r_waddr <= r_addr;
      for (int k = 0; k < NUM_REGS; k++)
        if (r_pend && r_addr == ADDR_W'(k)) r_regs[k] <= r_sr[DATA_W-1:0];
      if (r_state == IDLE && w_cs_fall) begin
        r_cnt <= '0;
        r_sr  <= '0;
      end else if (w_shift_in) begin
        r_sr  <= w_sr_next;
        r_cnt <= r_cnt + 1'b1;
        if (r_state == HEADER && r_cnt == HDR_LAST) begin
          r_rw   <= w_sr_next[ADDR_W];
          r_addr <= w_sr_next[ADDR_W-1:0];
          r_osr  <= w_rd_val;
        end
        if (r_state == DATA && r_cnt == FRM_LAST) r_pend <= r_rw && ({1'b0, r_addr} < NREG);
      end
      // the data MSB is already on CIPO after the header, so the first falling edge must not shift
      if (r_state == DATA && w_sclk_fall && r_cnt != HDR_BITS) r_osr <= r_osr << 1;
      r_cipo <= (r_state == DATA && !r_rw) ? r_osr[DATA_W-1] : 1'b0;
    end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign CIPO      = r_cipo;
  assign wr_strobe = r_strobe;
  assign wr_addr   = r_waddr;
  assign frame_err = r_ferr;
endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile: frame-level reference model with a per-cycle output compare
module tb_spi_regfile;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int NR = 5;
  localparam int S  = 2;
  localparam int F  = 1 + AW + DW;
  localparam int H  = 6;

  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, copi = 1'b0, cs = 1'b1;
  logic cipo, wr_strobe, frame_err;
  logic [NR*DW-1:0] regs_out;
  logic [AW-1:0] wr_addr;

  int checks = 0, errors = 0, ncyc = 0, commit_cyc = -1, commit_idx = 0;
  int ferr_cnt = 0, strobe_cnt = 0;
  logic chk_en = 1'b0, prev_ferr = 1'b0;
  logic [AW-1:0] commit_addr = '0, exp_waddr = '0;
  logic [DW-1:0] commit_data = '0;
  logic [DW-1:0] exp_regs [NR] = '{default: '0};
  logic [NR*DW-1:0] exp_vec;

  spi_regfile #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .COPI(copi), .cs(cs), .CIPO(cipo),
    .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      if (ncyc == commit_cyc) begin
        exp_regs[commit_idx] = commit_data;
        exp_waddr = commit_addr;
      end
      for (int k = 0; k < NR; k++) exp_vec[k*DW +: DW] = exp_regs[k];
      check("regs_out", regs_out, exp_vec);
      check("wr_strobe", wr_strobe, ncyc == commit_cyc);
      check("wr_addr", wr_addr, exp_waddr);
      check("frame_err_width", frame_err && prev_ferr, 0);
      if (frame_err) ferr_cnt++;
      if (wr_strobe) strobe_cnt++;
      prev_ferr = frame_err;
    end
  end

  task automatic do_frame(input logic [F-1:0] w, input int nbits, input int extra,
                          input bit rst_mid, output logic [DW-1:0] rd);
    logic rw;
    int addr, f0;
    logic [DW-1:0] rv;
    rw = w[F-1];
    addr = int'(w[F-2 -: AW]);
    rv = (addr < NR) ? exp_regs[addr] : '0;
    f0 = ferr_cnt;
    rd = '0;
    @(negedge clk);
    cs = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      copi = w[F-1-i];
      repeat (H) @(negedge clk);
      if (!rw && i > AW) begin
        rd = {rd[DW-2:0], cipo};
        check("cipo_data", cipo, rv[DW-1-(i-1-AW)]);
      end else check("cipo_header", cipo, 0);
      sclk = 1'b1;
      if (i == F-1 && rw && addr < NR) begin
        commit_cyc  = ncyc + S + 1;
        commit_idx  = addr;
        commit_addr = w[F-2 -: AW];
        commit_data = w[DW-1:0];
      end
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
    if (rst_mid) begin
      rst_n = 1'b0;
      commit_cyc = -1;
      foreach (exp_regs[k]) exp_regs[k] = '0;
      exp_waddr = '0;
      repeat (2) @(negedge clk);
      check("rst_regs", regs_out, 0);
      check("rst_cipo", cipo, 0);
      check("rst_strobe", wr_strobe, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_waddr", wr_addr, 0);
      cs = 1'b1;
      repeat (H) @(negedge clk);
      rst_n = 1'b1;
      repeat (2*H) @(negedge clk);
      check("rst_no_ferr", ferr_cnt - f0, 0);
    end else begin
      for (int e = 0; e < extra; e++) begin
        repeat (H) @(negedge clk);
        sclk = 1'b1;
        repeat (H) @(negedge clk);
        sclk = 1'b0;
        check("cipo_done", cipo, 0);
      end
      repeat (H) @(negedge clk);
      cs = 1'b1;
      repeat (2*H) @(negedge clk);
      check("cipo_after", cipo, 0);
      check("frame_err_count", ferr_cnt - f0, (nbits < F) ? 1 : 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] rd;
    logic [F-1:0] w;
    int s0, nb, ex;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_regs", regs_out, 0);
    check("reset_cipo", cipo, 0);
    check("reset_strobe", wr_strobe, 0);
    check("reset_ferr", frame_err, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    s0 = strobe_cnt;
    do_frame(16'h82F0, F, 0, 0, rd);
    check("w82F0_regs", regs_out, 40'h0000F00000);
    check("w82F0_strobes", strobe_cnt - s0, 1);
    check("w82F0_waddr", wr_addr, 2);

    do_frame(16'h0200, F, 0, 0, rd);
    check("r0200_bits", rd, 8'hF0);
    check("r0200_regs", regs_out, 40'h0000F00000);

    s0 = strobe_cnt;
    do_frame(16'h85AA, F, 0, 0, rd);
    check("w85AA_regs", regs_out, 40'h0000F00000);
    check("w85AA_strobes", strobe_cnt - s0, 0);
    do_frame(16'h0500, F, 0, 0, rd);
    check("r0500_bits", rd, 8'h00);

    do_frame(16'h8133, 10, 0, 0, rd);
    check("abort_regs", regs_out, 40'h0000F00000);
    do_frame(16'h8133, F, 0, 0, rd);
    check("w8133_regs", regs_out, 40'h0000F03300);

    s0 = strobe_cnt;
    do_frame(16'h8455, F, 4, 0, rd);
    check("w8455_regs", regs_out, 40'h5500F03300);
    check("w8455_strobes", strobe_cnt - s0, 1);

    do_frame(16'h8077, 12, 0, 1, rd);
    check("rst_mid_regs", regs_out, 0);
    do_frame(16'h8077, F, 0, 0, rd);
    check("w8077_regs", regs_out, 40'h0000000077);

    for (int n = 0; n < 60; n++) begin
      w = {1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom)};
      nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, F-1) : F;
      ex = (nb == F) ? $urandom_range(0, 2) : 0;
      do_frame(w, nb, ex, 0, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
